// File: rtl/ipa_gcm_arb_pkg.sv
// Shared types and constants for the GCM port arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ipa_gcm_arb_pkg;

   // Who owns the response returning from a bank one cycle after its request
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CTX  = 2'd1,
      OWN_DMA  = 2'd2
   } gcm_owner_e;

   // Fixed SRAM read latency; the response trackers are a single register stage
   localparam int   SRAM_LATENCY = 1;

   // wen encoding on the bank ports: 1 = read, 0 = write
   localparam logic WEN_READ     = 1'b1;

endpackage

// File: rtl/ipa_gcm_resp_tracker.sv
// Per-bank response tracker: remembers who was granted a bank last cycle and the DMA ID.
// Latency: owner/rvalid/rid appear one cycle after the grant (SRAM_LATENCY).
// Backpressure: none; responses cannot be stalled, they are reported exactly once.
//
// Ports:
//   clk, rst_n   : clock, async active-low reset (drops any in-flight response)
//   i_ctx_gnt    : context fetcher owns this bank this cycle
//   i_dma_gnt    : DMA owns this bank this cycle
//   i_id         : DMA transaction ID, captured only on a DMA grant
//   o_owner      : owner of the response currently returning
//   o_dma_rvalid : DMA response valid (reads and writes)
//   o_rid        : ID of the last granted DMA transaction
module ipa_gcm_resp_tracker
   import ipa_gcm_arb_pkg::*;
#(
   parameter int ID_WIDTH = 20
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_ctx_gnt,
   input  logic                i_dma_gnt,
   input  logic [ID_WIDTH-1:0] i_id,
   output gcm_owner_e          o_owner,
   output logic                o_dma_rvalid,
   output logic [ID_WIDTH-1:0] o_rid
);

   gcm_owner_e          r_owner;
   logic [ID_WIDTH-1:0] r_rid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner <= OWN_NONE;
         r_rid   <= '0;
      end else begin
         if (i_ctx_gnt)
            r_owner <= OWN_CTX;
         else if (i_dma_gnt)
            r_owner <= OWN_DMA;
         else
            r_owner <= OWN_NONE;
         // rid is held across ctx responses so a ctx read never overwrites it
         if (i_dma_gnt && !i_ctx_gnt)
            r_rid <= i_id;
      end
   end

   assign o_owner      = r_owner;
   assign o_dma_rvalid = (r_owner == OWN_DMA);
   assign o_rid        = r_rid;

endmodule

// File: rtl/ipa_gcm_port_arbiter.sv
// Arbitrates GCM SRAM banks between the lockstep context fetcher and per-bank DMA requests.
// Latency: grants combinational in the request cycle; responses one cycle later.
// Backpressure: ctx wins ties, but after MAX_CTX_BURST back-to-back ctx grants with DMA waiting, DMA wins one cycle.
//
// Ports:
//   ctx_*  : context fetch request/grant, read response (bank0 in the MSBs of ctx_rdata_o)
//   dma_*  : per-bank crossbar request/grant and response (bank b at slice b of each bus)
//   mem_*  : SRAM bank ports (bank b at slice b of each bus)
//   busy_o : context request present or a context response still returning
module ipa_gcm_port_arbiter
   import ipa_gcm_arb_pkg::*;
#(
   parameter int NB_BANKS       = 2,
   parameter int ADDR_MEM_WIDTH = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int BE_WIDTH       = 4,
   parameter int ID_WIDTH       = 20,
   parameter int MAX_CTX_BURST  = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             ctx_req_i,
   input  logic [ADDR_MEM_WIDTH-1:0]        ctx_addr_i,
   output logic                             ctx_gnt_o,
   output logic                             ctx_rvalid_o,
   output logic [NB_BANKS*DATA_WIDTH-1:0]   ctx_rdata_o,
   input  logic [NB_BANKS-1:0]              dma_req_i,
   input  logic [NB_BANKS*ADDR_MEM_WIDTH-1:0] dma_add_i,
   input  logic [NB_BANKS-1:0]              dma_wen_i,
   input  logic [NB_BANKS*DATA_WIDTH-1:0]   dma_wdata_i,
   input  logic [NB_BANKS*BE_WIDTH-1:0]     dma_be_i,
   input  logic [NB_BANKS*ID_WIDTH-1:0]     dma_id_i,
   output logic [NB_BANKS-1:0]              dma_gnt_o,
   output logic [NB_BANKS-1:0]              dma_rvalid_o,
   output logic [NB_BANKS*DATA_WIDTH-1:0]   dma_rdata_o,
   output logic [NB_BANKS*ID_WIDTH-1:0]     dma_rid_o,
   output logic [NB_BANKS-1:0]              mem_req_o,
   output logic [NB_BANKS*ADDR_MEM_WIDTH-1:0] mem_add_o,
   output logic [NB_BANKS-1:0]              mem_wen_o,
   output logic [NB_BANKS*DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [NB_BANKS*BE_WIDTH-1:0]     mem_be_o,
   input  logic [NB_BANKS*DATA_WIDTH-1:0]   mem_rdata_i,
   output logic                             busy_o
);

   localparam int             CW      = $clog2(MAX_CTX_BURST + 1);
   localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_CTX_BURST);

   logic [CW-1:0]       r_starv_cnt;
   logic                w_dma_any;
   logic                w_starved;
   logic                w_ctx_gnt;
   logic [NB_BANKS-1:0] w_dma_gnt;
   gcm_owner_e          w_owner [NB_BANKS];
   logic                w_ctx_pending;

   assign w_dma_any = |dma_req_i;
   assign w_starved = (r_starv_cnt == MAX_CNT);
   // ctx only yields when DMA is waiting and the burst budget is spent
   assign w_ctx_gnt = ctx_req_i && !(w_dma_any && w_starved);
   assign w_dma_gnt = w_ctx_gnt ? '0 : dma_req_i;

   assign ctx_gnt_o = w_ctx_gnt;
   assign dma_gnt_o = w_dma_gnt;

   // Counts ctx grants taken while DMA was waiting; anything else restarts the budget
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_starv_cnt <= '0;
      else if (w_ctx_gnt && w_dma_any) begin
         if (!w_starved)
            r_starv_cnt <= r_starv_cnt + 1'b1;
      end else
         r_starv_cnt <= '0;
   end

   // Bank port mux; idle banks are driven to zero
   always_comb begin
      mem_req_o   = '0;
      mem_add_o   = '0;
      mem_wen_o   = {NB_BANKS{WEN_READ}};
      mem_wdata_o = '0;
      mem_be_o    = '0;
      for (int b = 0; b < NB_BANKS; b++) begin
         if (w_ctx_gnt) begin
            mem_req_o[b]                               = 1'b1;
            mem_add_o[b*ADDR_MEM_WIDTH +: ADDR_MEM_WIDTH] = ctx_addr_i;
            mem_wen_o[b]                               = WEN_READ;
            mem_be_o[b*BE_WIDTH +: BE_WIDTH]           = '1;
         end else if (w_dma_gnt[b]) begin
            mem_req_o[b]                               = 1'b1;
            mem_add_o[b*ADDR_MEM_WIDTH +: ADDR_MEM_WIDTH] = dma_add_i[b*ADDR_MEM_WIDTH +: ADDR_MEM_WIDTH];
            mem_wen_o[b]                               = dma_wen_i[b];
            mem_wdata_o[b*DATA_WIDTH +: DATA_WIDTH]    = dma_wdata_i[b*DATA_WIDTH +: DATA_WIDTH];
            mem_be_o[b*BE_WIDTH +: BE_WIDTH]           = dma_be_i[b*BE_WIDTH +: BE_WIDTH];
         end
      end
   end

   // Context view reverses bank order: bank0 lands in the MSBs
   always_comb begin
      ctx_rdata_o = '0;
      for (int b = 0; b < NB_BANKS; b++)
         ctx_rdata_o[(NB_BANKS-1-b)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
   end

   assign dma_rdata_o = mem_rdata_i;

   for (genvar b = 0; b < NB_BANKS; b++) begin : g_trk
      ipa_gcm_resp_tracker #(.ID_WIDTH(ID_WIDTH)) u_trk (
         .clk          (clk),
         .rst_n        (rst_n),
         .i_ctx_gnt    (w_ctx_gnt),
         .i_dma_gnt    (w_dma_gnt[b]),
         .i_id         (dma_id_i[b*ID_WIDTH +: ID_WIDTH]),
         .o_owner      (w_owner[b]),
         .o_dma_rvalid (dma_rvalid_o[b]),
         .o_rid        (dma_rid_o[b*ID_WIDTH +: ID_WIDTH])
      );
   end

   // ctx always owns every bank together, so bank 0 speaks for all
   assign ctx_rvalid_o = (w_owner[0] == OWN_CTX);

   always_comb begin
      w_ctx_pending = 1'b0;
      for (int b = 0; b < NB_BANKS; b++)
         if (w_owner[b] == OWN_CTX)
            w_ctx_pending = 1'b1;
   end

   assign busy_o = ctx_req_i | w_ctx_pending;

endmodule

// File: tb/tb_ipa_gcm_port_arbiter.sv
module tb_ipa_gcm_port_arbiter;

   localparam int NB  = 2;
   localparam int AW  = 12;
   localparam int DW  = 32;
   localparam int BW  = 4;
   localparam int IW  = 20;
   localparam int MAX = 16;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 ctx_req_i;
   logic [AW-1:0]        ctx_addr_i;
   logic                 ctx_gnt_o, ctx_rvalid_o;
   logic [NB*DW-1:0]     ctx_rdata_o;
   logic [NB-1:0]        dma_req_i, dma_wen_i;
   logic [NB*AW-1:0]     dma_add_i;
   logic [NB*DW-1:0]     dma_wdata_i;
   logic [NB*BW-1:0]     dma_be_i;
   logic [NB*IW-1:0]     dma_id_i;
   logic [NB-1:0]        dma_gnt_o, dma_rvalid_o;
   logic [NB*DW-1:0]     dma_rdata_o;
   logic [NB*IW-1:0]     dma_rid_o;
   logic [NB-1:0]        mem_req_o, mem_wen_o;
   logic [NB*AW-1:0]     mem_add_o;
   logic [NB*DW-1:0]     mem_wdata_o;
   logic [NB*BW-1:0]     mem_be_o;
   logic [NB*DW-1:0]     mem_rdata_i;
   logic                 busy_o;

   always #5 clk = ~clk;

   ipa_gcm_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .ctx_req_i(ctx_req_i), .ctx_addr_i(ctx_addr_i), .ctx_gnt_o(ctx_gnt_o),
      .ctx_rvalid_o(ctx_rvalid_o), .ctx_rdata_o(ctx_rdata_o),
      .dma_req_i(dma_req_i), .dma_add_i(dma_add_i), .dma_wen_i(dma_wen_i),
      .dma_wdata_i(dma_wdata_i), .dma_be_i(dma_be_i), .dma_id_i(dma_id_i),
      .dma_gnt_o(dma_gnt_o), .dma_rvalid_o(dma_rvalid_o), .dma_rdata_o(dma_rdata_o),
      .dma_rid_o(dma_rid_o), .mem_req_o(mem_req_o), .mem_add_o(mem_add_o),
      .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: who should see a response next, and how many ctx wins DMA has sat through
   int            m_streak;
   int            m_own [NB];   // 0 none, 1 ctx, 2 dma
   logic [IW-1:0] m_rid [NB];

   logic          obs_ctx_gnt;
   logic [NB-1:0] obs_dma_gnt;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_streak = 0;
      for (int b = 0; b < NB; b++) begin
         m_own[b] = 0;
         m_rid[b] = '0;
      end
   endtask

   // Called at a negedge with inputs already applied; returns at the next negedge
   task automatic cycle();
      logic          eg;
      logic [NB-1:0] edg;
      logic          dany;
      logic          ctx_out;
      logic [NB*DW-1:0] exp_ctx;
      #1;
      dany = |dma_req_i;
      eg   = ctx_req_i && !(dany && m_streak == MAX);
      edg  = eg ? '0 : dma_req_i;
      chk("ctx_gnt", ctx_gnt_o, eg);
      chk("dma_gnt", dma_gnt_o, edg);
      chk("mem_req", mem_req_o, eg ? {NB{1'b1}} : edg);
      ctx_out = 1'b0;
      for (int b = 0; b < NB; b++) if (m_own[b] == 1) ctx_out = 1'b1;
      chk("busy", busy_o, ctx_req_i | ctx_out);
      chk("ctx_rvalid", ctx_rvalid_o, m_own[0] == 1);
      exp_ctx = '0;
      for (int b = 0; b < NB; b++) begin
         exp_ctx[(NB-1-b)*DW +: DW] = mem_rdata_i[b*DW +: DW];
         if (eg) begin
            chk($sformatf("ctx_add[%0d]", b), mem_add_o[b*AW +: AW], ctx_addr_i);
            chk($sformatf("ctx_wen[%0d]", b), mem_wen_o[b], 1'b1);
            chk($sformatf("ctx_be[%0d]", b), mem_be_o[b*BW +: BW], {BW{1'b1}});
         end else if (edg[b]) begin
            chk($sformatf("dma_add[%0d]", b), mem_add_o[b*AW +: AW], dma_add_i[b*AW +: AW]);
            chk($sformatf("dma_wen[%0d]", b), mem_wen_o[b], dma_wen_i[b]);
            chk($sformatf("dma_wdata[%0d]", b), mem_wdata_o[b*DW +: DW], dma_wdata_i[b*DW +: DW]);
            chk($sformatf("dma_be[%0d]", b), mem_be_o[b*BW +: BW], dma_be_i[b*BW +: BW]);
         end else begin
            chk($sformatf("idle_add[%0d]", b), mem_add_o[b*AW +: AW], '0);
            chk($sformatf("idle_be[%0d]", b), mem_be_o[b*BW +: BW], '0);
         end
         chk($sformatf("dma_rvalid[%0d]", b), dma_rvalid_o[b], m_own[b] == 2);
         chk($sformatf("dma_rid[%0d]", b), dma_rid_o[b*IW +: IW], m_rid[b]);
         if (m_own[b] == 2)
            chk($sformatf("dma_rdata[%0d]", b), dma_rdata_o[b*DW +: DW], mem_rdata_i[b*DW +: DW]);
      end
      if (m_own[0] == 1) chk("ctx_rdata", ctx_rdata_o, exp_ctx);
      obs_ctx_gnt = ctx_gnt_o;
      obs_dma_gnt = dma_gnt_o;
      @(posedge clk);
      for (int b = 0; b < NB; b++) begin
         m_own[b] = eg ? 1 : (edg[b] ? 2 : 0);
         if (edg[b]) m_rid[b] = dma_id_i[b*IW +: IW];
      end
      if (eg && dany) m_streak = (m_streak < MAX) ? m_streak + 1 : MAX;
      else            m_streak = 0;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      ctx_req_i = 0; ctx_addr_i = '0; dma_req_i = '0; dma_add_i = '0;
      dma_wen_i = '1; dma_wdata_i = '0; dma_be_i = '0; dma_id_i = '0;
   endtask

   initial begin
      int run, max_run, dgr;
      logic [DW-1:0] w;
      rst_n = 0;
      idle_inputs();
      mem_rdata_i = '0;
      model_reset();
      @(negedge clk);
      #1;
      chk("rst_ctx_rvalid", ctx_rvalid_o, 1'b0);
      chk("rst_dma_rvalid", dma_rvalid_o, '0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_rid", dma_rid_o, '0);
      @(negedge clk);
      rst_n = 1;

      // ctx read of 0x010, bank0 returns AAAA0000, bank1 returns 0000BBBB
      ctx_req_i = 1; ctx_addr_i = 12'h010;
      cycle();
      ctx_req_i = 0;
      mem_rdata_i = {32'h0000BBBB, 32'hAAAA0000};
      #1;
      chk("t1_ctx_rvalid", ctx_rvalid_o, 1'b1);
      chk("t1_ctx_rdata", ctx_rdata_o, 64'hAAAA00000000BBBB);
      cycle();

      // DMA write on bank1 only
      dma_req_i = 2'b10; dma_wen_i = 2'b01;
      dma_add_i[AW +: AW] = 12'h3FF; dma_wdata_i[DW +: DW] = 32'hDEADBEEF;
      dma_be_i[BW +: BW] = 4'hF; dma_id_i[IW +: IW] = 20'd5;
      cycle();
      dma_req_i = '0;
      #1;
      chk("t2_dma_rvalid", dma_rvalid_o, 2'b10);
      chk("t2_rid1", dma_rid_o[IW +: IW], 20'd5);
      cycle();

      // Starvation: ctx and dma_req[0] held for 40 cycles -> 16 ctx, 1 dma repeating
      idle_inputs();
      ctx_req_i = 1; dma_req_i = 2'b01; dma_id_i[0 +: IW] = 20'h00ABC;
      run = 0; max_run = 0; dgr = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (obs_ctx_gnt) begin run++; if (run > max_run) max_run = run; end
         else run = 0;
         if (obs_dma_gnt[0]) dgr++;
      end
      chk("starv_max_run", max_run, MAX);
      chk("starv_dma_grants", dgr, 2);

      // ctx drops: the held DMA request goes through in that same cycle
      ctx_req_i = 0;
      cycle();
      chk("held_dma_gnt", obs_dma_gnt, 2'b01);

      // Alternating ctx/DMA grants on both banks
      for (int i = 0; i < 8; i++) begin
         ctx_req_i = i[0]; ctx_addr_i = AW'($urandom);
         dma_req_i = i[0] ? 2'b00 : 2'b11;
         dma_id_i = (NB*IW)'({$urandom, $urandom});
         mem_rdata_i = {$urandom, $urandom};
         cycle();
      end

      // Reset the cycle after a ctx grant
      idle_inputs();
      ctx_req_i = 1;
      cycle();
      ctx_req_i = 0; rst_n = 0;
      model_reset();
      #1;
      chk("mid_rst_ctx_rvalid", ctx_rvalid_o, 1'b0);
      chk("mid_rst_busy", busy_o, 1'b0);
      chk("mid_rst_rid", dma_rid_o, '0);
      @(negedge clk);
      rst_n = 1;
      ctx_req_i = 1; dma_req_i = 2'b11;
      cycle();

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         ctx_req_i   = ($urandom_range(0, 9) < 6);
         ctx_addr_i  = AW'($urandom);
         dma_req_i   = NB'($urandom);
         dma_wen_i   = NB'($urandom);
         dma_add_i   = (NB*AW)'($urandom);
         dma_wdata_i = {$urandom, $urandom};
         dma_be_i    = (NB*BW)'($urandom);
         dma_id_i    = (NB*IW)'({$urandom, $urandom});
         w = $urandom;
         mem_rdata_i = {w, $urandom};
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
